// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU controller.
// Opcode encodings mirror the alu opcode_i field; 0 and 15 are left undefined.
package cpu_ctrl_pkg;

  localparam int OPW_DEF = 4;

  localparam logic [3:0] ADD_OP = 4'd1;
  localparam logic [3:0] SUB_OP = 4'd2;
  localparam logic [3:0] MUL_OP = 4'd3;
  localparam logic [3:0] DIV_OP = 4'd4;
  localparam logic [3:0] AND_OP = 4'd5;
  localparam logic [3:0] OR_OP  = 4'd6;
  localparam logic [3:0] XOR_OP = 4'd7;
  localparam logic [3:0] LI_OP  = 4'd8;
  localparam logic [3:0] LW_OP  = 4'd9;
  localparam logic [3:0] SW_OP  = 4'd10;
  localparam logic [3:0] JMP_OP = 4'd11;
  localparam logic [3:0] BEQ_OP = 4'd12;
  localparam logic [3:0] BGT_OP = 4'd13;
  localparam logic [3:0] BLT_OP = 4'd14;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    TRAP    = 3'd5
  } state_e;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_MEM = 2'd1;
  localparam logic [1:0] WSEL_IMM = 2'd2;

endpackage

// File: rtl/cpu_ctrl_if.sv
// Memory request handshake between the controller (master) and memory (slave).
interface cpu_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input  mem_ready);
  modport slave  (input  mem_req, input  mem_we, output mem_ready);
endinterface

// File: rtl/cpu_ctrl_stall_cnt.sv
// Loadable down-counter with zero flag; holds EXECUTE open for MUL/DIV.
module ctrl_stall_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXECUTE/MEM/WB around a shared alu.
// Build option: define CPU_CTRL_ILLEGAL_TRAP_EN to trap on undefined opcodes (else NOP).
module cpu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW        = OPW_DEF,
  parameter int MULDIV_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode_i,
  input  logic           cmp_eq_i,
  input  logic           cmp_gt_i,
  input  logic           cmp_lt_i,
  cpu_ctrl_if.master     mem,
  output logic           ir_we_o,
  output logic           pc_we_o,
  output logic           pc_src_o,
  output logic [OPW-1:0] alu_op_o,
  output logic           alu_src_b_o,
  output logic           rf_we_o,
  output logic [1:0]     rf_wsel_o,
  output logic           retire_o,
  output logic           trap_o,
  output logic [2:0]     state_o
);

  localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

  state_e state_q, state_d;

  logic is_arith, is_muldiv, is_li, is_lw, is_sw, is_jmp, is_br, br_taken, legal;
  logic is_mem, imm_op, exec_last;
  logic cnt_load, cnt_dec, cnt_zero;

  logic           mem_req_c, mem_we_c, ir_we_c, pc_we_c, pc_src_c;
  logic [OPW-1:0] alu_op_c;
  logic           alu_src_b_c, rf_we_c, retire_c;
  logic [1:0]     rf_wsel_c;

  // Opcode classification
  always_comb begin
    is_arith  = 1'b0;
    is_muldiv = 1'b0;
    is_li     = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_jmp    = 1'b0;
    is_br     = 1'b0;
    br_taken  = 1'b0;
    case (opcode_i)
      OPW'(ADD_OP), OPW'(SUB_OP), OPW'(AND_OP),
      OPW'(OR_OP),  OPW'(XOR_OP):                is_arith = 1'b1;
      OPW'(MUL_OP), OPW'(DIV_OP): begin
        is_arith  = 1'b1;
        is_muldiv = 1'b1;
      end
      OPW'(LI_OP):  is_li  = 1'b1;
      OPW'(LW_OP):  is_lw  = 1'b1;
      OPW'(SW_OP):  is_sw  = 1'b1;
      OPW'(JMP_OP): is_jmp = 1'b1;
      OPW'(BEQ_OP): begin is_br = 1'b1; br_taken = cmp_eq_i; end
      OPW'(BGT_OP): begin is_br = 1'b1; br_taken = cmp_gt_i; end
      OPW'(BLT_OP): begin is_br = 1'b1; br_taken = cmp_lt_i; end
      default: ;
    endcase
  end

  assign legal     = is_arith | is_li | is_lw | is_sw | is_jmp | is_br;
  assign is_mem    = is_lw | is_sw;
  assign imm_op    = is_li | is_lw | is_sw;
  assign exec_last = !is_muldiv || cnt_zero;

  ctrl_stall_cnt #(.W(CW)) u_stall (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (CW'(MULDIV_LAT - 1)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  logic trap_q, trap_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    pc_src_c    = 1'b0;
    alu_op_c    = '0;
    alu_src_b_c = 1'b0;
    rf_we_c     = 1'b0;
    rf_wsel_c   = WSEL_ALU;
    retire_c    = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    trap_d      = trap_q;
`endif
    case (state_q)
      FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        alu_op_c = opcode_i;
        cnt_load = 1'b1;
        if (legal) begin
          state_d = EXECUTE;
        end else begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
          state_d = TRAP;
          trap_d  = 1'b1;
`else
          retire_c = 1'b1;
          state_d  = FETCH;
`endif
        end
      end
      EXECUTE: begin
        alu_op_c    = opcode_i;
        alu_src_b_c = imm_op;
        if (!exec_last) begin
          cnt_dec = 1'b1;
        end else if (is_arith || is_li) begin
          state_d = WB;
        end else if (is_mem) begin
          state_d = MEM;
        end else begin
          // Jumps and branches resolve here; untaken branches just retire
          pc_we_c  = is_jmp | br_taken;
          pc_src_c = is_jmp | br_taken;
          retire_c = 1'b1;
          state_d  = FETCH;
        end
      end
      MEM: begin
        mem_req_c   = 1'b1;
        mem_we_c    = is_sw;
        alu_op_c    = opcode_i;
        alu_src_b_c = 1'b1;
        if (mem.mem_ready) begin
          if (is_sw) begin
            retire_c = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d  = WB;
          end
        end
      end
      WB: begin
        rf_we_c   = 1'b1;
        rf_wsel_c = is_li ? WSEL_IMM : (is_lw ? WSEL_MEM : WSEL_ALU);
        retire_c  = 1'b1;
        state_d   = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are forced low while rst is held, before the state register clears
  assign mem.mem_req = !rst && mem_req_c;
  assign mem.mem_we  = !rst && mem_we_c;
  assign ir_we_o     = !rst && ir_we_c;
  assign pc_we_o     = !rst && pc_we_c;
  assign pc_src_o    = !rst && pc_src_c;
  assign alu_op_o    = rst ? '0 : alu_op_c;
  assign alu_src_b_o = !rst && alu_src_b_c;
  assign rf_we_o     = !rst && rf_we_c;
  assign rf_wsel_o   = rst ? WSEL_ALU : rf_wsel_c;
  assign retire_o    = !rst && retire_c;
  assign state_o     = rst ? 3'd0 : state_q;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  assign trap_o      = !rst && trap_q;
`else
  assign trap_o      = 1'b0;
`endif

endmodule
